// File: rtl/vga_mon_pkg.sv
// Shared types and default 640x480 timing for the VGA frame monitor.
package vga_mon_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam logic [23:0] DEF_TARGET_RGB = 24'hFF0000;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // Counters stick at all-ones so an overlong line or frame can never wrap into a pass.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector for one sync line, sampled only on pixel strobes.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic din,
  output logic fall
);

  logic q_reg;

  // Resets low so a sync already low at reset release is not mistaken for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= 1'b0;
    end else if (pix_en) begin
      q_reg <= din;
    end
  end

  assign fall = pix_en & q_reg & ~din;

endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers VGA raster timing, verifies geometry, locks, and reports the first target-colour pixel per frame.
// Optional bounding-box outputs are built when VGA_MON_BBOX_EN is defined.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int          H_TOTAL    = DEF_H_TOTAL,
  parameter int          V_TOTAL    = DEF_V_TOTAL,
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter logic [23:0] TARGET_RGB = DEF_TARGET_RGB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        locked,
  output logic        frame_done,
  output logic        geom_err,
  output logic        hit_valid,
  output logic [9:0]  hit_x,
  output logic [9:0]  hit_y,
  output logic [15:0] frame_cnt
`ifdef VGA_MON_BBOX_EN
  ,
  output logic [9:0]  bbox_min_x,
  output logic [9:0]  bbox_max_x,
  output logic [9:0]  bbox_min_y,
  output logic [9:0]  bbox_max_y
`endif
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_TOT  = COORD_W'(V_TOTAL);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);

  logic [1:0] sync_in;
  logic [1:0] sync_fall;
  logic       hs_fall;
  logic       vs_fall;

  assign sync_in = {vga_vs, vga_hs};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_edge
    vga_edge_det u_edge (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en),
      .din    (sync_in[gi]),
      .fall   (sync_fall[gi])
    );
  end

  assign hs_fall = sync_fall[0];
  assign vs_fall = sync_fall[1];

  mon_state_t         state_reg, state_next;
  logic [COORD_W-1:0] h_cnt_reg, h_cnt_next;
  logic [COORD_W-1:0] act_px_reg, act_px_next;
  logic [COORD_W-1:0] v_cnt_reg, v_cnt_next;
  logic [COORD_W-1:0] act_lines_reg, act_lines_next;
  logic               mismatch_reg, mismatch_next;
  logic               match_reg, match_next;
  logic [COORD_W-1:0] shadow_x_reg, shadow_x_next;
  logic [COORD_W-1:0] shadow_y_reg, shadow_y_next;
  logic               frame_done_reg, frame_done_next;
  logic               geom_err_reg, geom_err_next;
  logic               hit_valid_reg, hit_valid_next;
  logic [COORD_W-1:0] hit_x_reg, hit_x_next;
  logic [COORD_W-1:0] hit_y_reg, hit_y_next;
  logic [15:0]        frame_cnt_reg, frame_cnt_next;
`ifdef VGA_MON_BBOX_EN
  logic [COORD_W-1:0] acc_min_x_reg, acc_min_x_next;
  logic [COORD_W-1:0] acc_max_x_reg, acc_max_x_next;
  logic [COORD_W-1:0] acc_min_y_reg, acc_min_y_next;
  logic [COORD_W-1:0] acc_max_y_reg, acc_max_y_next;
  logic [COORD_W-1:0] bbox_min_x_reg, bbox_min_x_next;
  logic [COORD_W-1:0] bbox_max_x_reg, bbox_max_x_next;
  logic [COORD_W-1:0] bbox_min_y_reg, bbox_min_y_next;
  logic [COORD_W-1:0] bbox_max_y_reg, bbox_max_y_next;
`endif

  logic               fail_h;
  logic               fail_v;
  logic               chk_fail;
  logic [COORD_W-1:0] px_x;

  always_comb begin
    state_next      = state_reg;
    h_cnt_next      = h_cnt_reg;
    act_px_next     = act_px_reg;
    v_cnt_next      = v_cnt_reg;
    act_lines_next  = act_lines_reg;
    mismatch_next   = mismatch_reg;
    match_next      = match_reg;
    shadow_x_next   = shadow_x_reg;
    shadow_y_next   = shadow_y_reg;
    frame_done_next = 1'b0;
    geom_err_next   = 1'b0;
    hit_valid_next  = hit_valid_reg;
    hit_x_next      = hit_x_reg;
    hit_y_next      = hit_y_reg;
    frame_cnt_next  = frame_cnt_reg;
`ifdef VGA_MON_BBOX_EN
    acc_min_x_next  = acc_min_x_reg;
    acc_max_x_next  = acc_max_x_reg;
    acc_min_y_next  = acc_min_y_reg;
    acc_max_y_next  = acc_max_y_reg;
    bbox_min_x_next = bbox_min_x_reg;
    bbox_max_x_next = bbox_max_x_reg;
    bbox_min_y_next = bbox_min_y_reg;
    bbox_max_y_next = bbox_max_y_reg;
`endif
    fail_h   = 1'b0;
    fail_v   = 1'b0;
    chk_fail = 1'b0;
    px_x     = '0;

    if (pix_en) begin
      h_cnt_next = sat_inc(h_cnt_reg);

      if (hs_fall) begin
        fail_h = (h_cnt_reg != H_LAST) ||
                 ((act_px_reg != '0) && (act_px_reg != H_ACT));
        h_cnt_next  = '0;
        act_px_next = '0;
        v_cnt_next  = sat_inc(v_cnt_reg);
        if (act_px_reg != '0) begin
          act_lines_next = sat_inc(act_lines_reg);
        end
      end

      // Frame checks see the line totals already updated by a coincident HS fall.
      if (vs_fall) begin
        fail_v = (v_cnt_next != V_TOT) || (act_lines_next != V_ACT);
        v_cnt_next     = '0;
        act_lines_next = '0;
      end

      chk_fail = (state_reg != SEARCH) && (fail_h || fail_v);

      if (vs_fall) begin
        frame_done_next = 1'b1;
        mismatch_next   = 1'b0;
        match_next      = 1'b0;
`ifdef VGA_MON_BBOX_EN
        acc_min_x_next  = COORD_MAX;
        acc_max_x_next  = '0;
        acc_min_y_next  = COORD_MAX;
        acc_max_y_next  = '0;
`endif
        case (state_reg)
          SEARCH: state_next = ACQUIRE;
          ACQUIRE: begin
            if (!mismatch_reg && !chk_fail) begin
              state_next = LOCKED;
            end
          end
          LOCKED: begin
            if (!chk_fail) begin
              frame_cnt_next = frame_cnt_reg + 16'd1;
              hit_valid_next = match_reg;
              if (match_reg) begin
                hit_x_next = shadow_x_reg;
                hit_y_next = shadow_y_reg;
`ifdef VGA_MON_BBOX_EN
                bbox_min_x_next = acc_min_x_reg;
                bbox_max_x_next = acc_max_x_reg;
                bbox_min_y_next = acc_min_y_reg;
                bbox_max_y_next = acc_max_y_reg;
`endif
              end
            end
          end
          default: state_next = SEARCH;
        endcase
      end else if (chk_fail) begin
        mismatch_next = 1'b1;
        match_next    = 1'b0;
      end

      if (chk_fail && (state_reg == LOCKED)) begin
        geom_err_next = 1'b1;
        state_next    = ACQUIRE;
      end

      // Coordinates come from the post-sync counters, so a sync pixel starts the new line/frame.
      if (vga_blank) begin
        px_x        = act_px_next;
        act_px_next = sat_inc(act_px_next);
        if ({vga_r, vga_g, vga_b} == TARGET_RGB) begin
          if (!match_next) begin
            match_next    = 1'b1;
            shadow_x_next = px_x;
            shadow_y_next = act_lines_next;
          end
`ifdef VGA_MON_BBOX_EN
          if (px_x < acc_min_x_next)           acc_min_x_next = px_x;
          if (px_x > acc_max_x_next)           acc_max_x_next = px_x;
          if (act_lines_next < acc_min_y_next) acc_min_y_next = act_lines_next;
          if (act_lines_next > acc_max_y_next) acc_max_y_next = act_lines_next;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= SEARCH;
      h_cnt_reg      <= '0;
      act_px_reg     <= '0;
      v_cnt_reg      <= '0;
      act_lines_reg  <= '0;
      mismatch_reg   <= 1'b0;
      match_reg      <= 1'b0;
      shadow_x_reg   <= '0;
      shadow_y_reg   <= '0;
      frame_done_reg <= 1'b0;
      geom_err_reg   <= 1'b0;
      hit_valid_reg  <= 1'b0;
      hit_x_reg      <= '0;
      hit_y_reg      <= '0;
      frame_cnt_reg  <= '0;
`ifdef VGA_MON_BBOX_EN
      acc_min_x_reg  <= COORD_MAX;
      acc_max_x_reg  <= '0;
      acc_min_y_reg  <= COORD_MAX;
      acc_max_y_reg  <= '0;
      bbox_min_x_reg <= '0;
      bbox_max_x_reg <= '0;
      bbox_min_y_reg <= '0;
      bbox_max_y_reg <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      h_cnt_reg      <= h_cnt_next;
      act_px_reg     <= act_px_next;
      v_cnt_reg      <= v_cnt_next;
      act_lines_reg  <= act_lines_next;
      mismatch_reg   <= mismatch_next;
      match_reg      <= match_next;
      shadow_x_reg   <= shadow_x_next;
      shadow_y_reg   <= shadow_y_next;
      frame_done_reg <= frame_done_next;
      geom_err_reg   <= geom_err_next;
      hit_valid_reg  <= hit_valid_next;
      hit_x_reg      <= hit_x_next;
      hit_y_reg      <= hit_y_next;
      frame_cnt_reg  <= frame_cnt_next;
`ifdef VGA_MON_BBOX_EN
      acc_min_x_reg  <= acc_min_x_next;
      acc_max_x_reg  <= acc_max_x_next;
      acc_min_y_reg  <= acc_min_y_next;
      acc_max_y_reg  <= acc_max_y_next;
      bbox_min_x_reg <= bbox_min_x_next;
      bbox_max_x_reg <= bbox_max_x_next;
      bbox_min_y_reg <= bbox_min_y_next;
      bbox_max_y_reg <= bbox_max_y_next;
`endif
    end
  end

  assign locked     = (state_reg == LOCKED);
  assign frame_done = frame_done_reg;
  assign geom_err   = geom_err_reg;
  assign hit_valid  = hit_valid_reg;
  assign hit_x      = hit_x_reg;
  assign hit_y      = hit_y_reg;
  assign frame_cnt  = frame_cnt_reg;
`ifdef VGA_MON_BBOX_EN
  assign bbox_min_x = bbox_min_x_reg;
  assign bbox_max_x = bbox_max_x_reg;
  assign bbox_min_y = bbox_min_y_reg;
  assign bbox_max_y = bbox_max_y_reg;
`endif

endmodule
